plab3_mem_wben_splitter: RTL and testbench

Reverse direction of the write-byte-enable decoder. It accepts one cache-line-wide write (line data plus per-byte enable mask) and re-encodes it as a sequence of word-granular writes. Each output beat carries a word index, a 4-bit byte mask and a 32-bit data word. It sits between the line-wide write path and word-wide memory/bank ports, with val/rdy handshakes on both sides.

---
 rtl/plab3_mem_wben_splitter_pkg.sv | 17 +
 rtl/plab3_mem_wben_splitter_if.sv | 33 +++
 rtl/plab3_mem_wben_prio_enc.sv | 32 +++
 rtl/plab3_mem_wben_splitter.sv | 93 +++++++++
 tb/tb_plab3_mem_wben_splitter.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/plab3_mem_wben_splitter_pkg.sv
// Shared constants and state encoding for the line-write splitter and the wben decoder.
package plab3_mem_wben_splitter_pkg;

  localparam int unsigned C_BYTES_PER_WORD = 4;
  localparam int unsigned C_WORD_NBITS     = 32;
  localparam int unsigned C_WORDS_PER_LINE = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } state_e;

  function automatic int unsigned words_per_line(input int unsigned idx_nbits);
    return 32'd1 << idx_nbits;
  endfunction

endpackage

// File: rtl/plab3_mem_wben_splitter_if.sv
// Line-wide write request in, word-granular write beats out, with val/rdy on both sides.
interface plab3_mem_wben_splitter_if
  import plab3_mem_wben_splitter_pkg::*;
#(
  parameter int p_in_nbits = 2
);
  localparam int c_nwords     = 1 << p_in_nbits;
  localparam int c_wben_nbits = C_BYTES_PER_WORD * c_nwords;
  localparam int c_data_nbits = C_WORD_NBITS * c_nwords;

  logic                    domain;
  logic                    in_val;
  logic                    in_rdy;
  logic [c_wben_nbits-1:0] in_wben;
  logic [c_data_nbits-1:0] in_data;
  logic                    out_val;
  logic                    out_rdy;
  logic [p_in_nbits-1:0]   out_idx;
  logic [3:0]              out_bmask;
  logic [31:0]             out_data;
  logic                    out_last;

  modport slave (
    input  domain, in_val, in_wben, in_data, out_rdy,
    output in_rdy, out_val, out_idx, out_bmask, out_data, out_last
  );

  modport master (
    output domain, in_val, in_wben, in_data, out_rdy,
    input  in_rdy, out_val, out_idx, out_bmask, out_data, out_last
  );

endinterface

// File: rtl/plab3_mem_wben_prio_enc.sv
// Finds the lowest word with a nonzero byte-enable nibble and whether it is the only one left.
module plab3_mem_wben_prio_enc
  import plab3_mem_wben_splitter_pkg::*;
#(
  parameter int p_in_nbits = 2
) (
  input  logic [C_BYTES_PER_WORD*(1<<p_in_nbits)-1:0] mask,
  output logic [p_in_nbits-1:0]                       idx,
  output logic                                        found,
  output logic                                        last
);
  localparam int c_nwords = 1 << p_in_nbits;

  logic [c_nwords-1:0] nz;

  always_comb begin
    nz    = '0;
    idx   = '0;
    found = 1'b0;
    last  = 1'b0;
    for (int i = 0; i < c_nwords; i++) begin
      nz[i] = |mask[C_BYTES_PER_WORD*i +: C_BYTES_PER_WORD];
    end
    for (int i = c_nwords - 1; i >= 0; i--) begin
      if (nz[i]) idx = i[p_in_nbits-1:0];
    end
    found = |nz;
    // exactly one nonzero nibble remains
    last  = found && ((nz & (nz - c_nwords'(1))) == '0);
  end

endmodule

// File: rtl/plab3_mem_wben_splitter.sv
// Splits one masked line write into word writes, skipping words with no enabled bytes.
//   state | meaning
//   IDLE  | ready for a line write; no beats pending
//   SPLIT | emitting one beat per nonzero nibble of rem_mask, lowest word first
module plab3_mem_wben_splitter
  import plab3_mem_wben_splitter_pkg::*;
#(
  parameter int p_in_nbits = 2
) (
  input logic                      clk,
  input logic                      reset,
  plab3_mem_wben_splitter_if.slave io
);
  localparam int c_nwords     = 1 << p_in_nbits;
  localparam int c_wben_nbits = C_BYTES_PER_WORD * c_nwords;
  localparam int c_data_nbits = C_WORD_NBITS * c_nwords;

  state_e                  state_q, state_d;
  logic [c_wben_nbits-1:0] rem_mask_q, rem_mask_d;
  logic [c_data_nbits-1:0] line_data_q, line_data_d;

  logic [p_in_nbits-1:0]   enc_idx;
  logic                    enc_found;
  logic                    enc_last;

  // domain only labels the transaction; no datapath decision depends on it
  logic domain_unused;
  assign domain_unused = io.domain;

  plab3_mem_wben_prio_enc #(
    .p_in_nbits (p_in_nbits)
  ) u_prio_enc (
    .mask  (rem_mask_q),
    .idx   (enc_idx),
    .found (enc_found),
    .last  (enc_last)
  );

  always_comb begin
    state_d      = state_q;
    rem_mask_d   = rem_mask_q;
    line_data_d  = line_data_q;
    io.in_rdy    = 1'b0;
    io.out_val   = 1'b0;
    io.out_idx   = '0;
    io.out_bmask = '0;
    io.out_data  = '0;
    io.out_last  = 1'b0;

    if (!reset) begin
      case (state_q)
        IDLE: begin
          io.in_rdy = 1'b1;
          if (io.in_val) begin
            rem_mask_d  = io.in_wben;
            line_data_d = io.in_data;
            // an all-zero mask is accepted and dropped without beats
            if (|io.in_wben) state_d = SPLIT;
          end
        end
        SPLIT: begin
          if (enc_found) begin
            io.out_val   = 1'b1;
            io.out_idx   = enc_idx;
            io.out_bmask = rem_mask_q[C_BYTES_PER_WORD*enc_idx +: C_BYTES_PER_WORD];
            io.out_data  = line_data_q[C_WORD_NBITS*enc_idx +: C_WORD_NBITS];
            io.out_last  = enc_last;
            if (io.out_rdy) begin
              rem_mask_d[C_BYTES_PER_WORD*enc_idx +: C_BYTES_PER_WORD] = '0;
              if (enc_last) state_d = IDLE;
            end
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rem_mask_q  <= '0;
      line_data_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_mask_q  <= rem_mask_d;
      line_data_q <= line_data_d;
    end
  end

endmodule

// File: tb/tb_plab3_mem_wben_splitter.sv
// Bench for the line-write splitter: directed table, corner sequences and random traffic vs a beat-list model.
module tb_plab3_mem_wben_splitter;

  localparam int P  = 2;
  localparam int NW = 1 << P;

  typedef struct {
    logic [15:0]  wben;
    logic [127:0] data;
  } line_t;

  typedef struct {
    logic [1:0]  idx;
    logic [3:0]  bmask;
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    logic [15:0] wben;
    int          nbeats;
    logic [7:0]  idxs;
    logic [15:0] bmasks;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  plab3_mem_wben_splitter_if #(.p_in_nbits(P)) io ();

  plab3_mem_wben_splitter #(.p_in_nbits(P)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io.slave)
  );

  line_t lines_q[$];
  beat_t exp_q[$];
  beat_t log_q[$];
  bit    rdy_pat_q[$];
  vec_t  vecs[8];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected beats of one line: every word with a nonzero nibble, ascending, last flag on the final one.
  function automatic void model_line(input line_t l);
    int    first;
    logic [3:0] nib;
    beat_t b;
    first = exp_q.size();
    for (int w = 0; w < NW; w++) begin
      nib = l.wben[4*w +: 4];
      if (nib != 4'h0) begin
        b.idx   = w[1:0];
        b.bmask = nib;
        b.data  = l.data[32*w +: 32];
        b.last  = 1'b0;
        exp_q.push_back(b);
      end
    end
    if (exp_q.size() > first) exp_q[exp_q.size()-1].last = 1'b1;
  endfunction

  function automatic logic [127:0] rand_line_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drives queued lines and out_rdy cycle by cycle from the negedge, checking every output against the model.
  task automatic run(input int rdy_pct, input int gap_pct, input int budget);
    int    cyc;
    bit    rdy;
    line_t l;
    beat_t b;
    cyc = 0;
    while ((lines_q.size() != 0 || exp_q.size() != 0) && cyc < budget) begin
      io.in_val = (lines_q.size() != 0) && ($urandom_range(99) >= gap_pct);
      if (lines_q.size() != 0) begin
        io.in_wben = lines_q[0].wben;
        io.in_data = lines_q[0].data;
      end
      if (rdy_pat_q.size() != 0) rdy = rdy_pat_q.pop_front();
      else                       rdy = ($urandom_range(99) < rdy_pct);
      io.out_rdy = rdy;
      #1;
      check("in_rdy", 32'(io.in_rdy), 32'(exp_q.size() == 0));
      check("out_val", 32'(io.out_val), 32'(exp_q.size() != 0));
      if (io.out_val && exp_q.size() != 0) begin
        check("out_idx", 32'(io.out_idx), 32'(exp_q[0].idx));
        check("out_bmask", 32'(io.out_bmask), 32'(exp_q[0].bmask));
        check("out_data", io.out_data, exp_q[0].data);
        check("out_last", 32'(io.out_last), 32'(exp_q[0].last));
        if (rdy) begin
          b.idx   = io.out_idx;
          b.bmask = io.out_bmask;
          b.data  = io.out_data;
          b.last  = io.out_last;
          log_q.push_back(b);
          void'(exp_q.pop_front());
        end
      end else if (!io.out_val) begin
        check("idle_idx", 32'(io.out_idx), 32'd0);
        check("idle_bmask", 32'(io.out_bmask), 32'd0);
        check("idle_last", 32'(io.out_last), 32'd0);
      end
      if (io.in_val && io.in_rdy) begin
        l = lines_q.pop_front();
        model_line(l);
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    io.in_val = 1'b0;
    check("drained", 32'(lines_q.size() + exp_q.size()), 32'd0);
    #1;
    check("after_rdy", 32'(io.in_rdy), 32'd1);
    check("after_val", 32'(io.out_val), 32'd0);
    lines_q.delete();
    exp_q.delete();
    rdy_pat_q.delete();
  endtask

  initial begin
    logic [127:0] d;
    line_t        l;

    vecs[0] = '{16'hFFFF, 4, 8'hE4, 16'hFFFF};
    vecs[1] = '{16'h0F00, 1, 8'h02, 16'h000F};
    vecs[2] = '{16'h3010, 2, 8'h0D, 16'h0031};
    vecs[3] = '{16'h0000, 0, 8'h00, 16'h0000};
    vecs[4] = '{16'h000F, 1, 8'h00, 16'h000F};
    vecs[5] = '{16'h8001, 2, 8'h0C, 16'h0081};
    vecs[6] = '{16'h0600, 1, 8'h02, 16'h0006};
    vecs[7] = '{16'hF0F0, 2, 8'h0D, 16'h00FF};

    io.domain  = 1'b0;
    io.in_val  = 1'b0;
    io.in_wben = '0;
    io.in_data = '0;
    io.out_rdy = 1'b0;
    reset      = 1'b1;

    // reset behaviour
    @(negedge clk);
    io.in_val = 1'b1;
    #1;
    check("rst_in_rdy", 32'(io.in_rdy), 32'd0);
    check("rst_out_val", 32'(io.out_val), 32'd0);
    check("rst_out_last", 32'(io.out_last), 32'd0);
    io.in_val = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_in_rdy", 32'(io.in_rdy), 32'd1);
    check("post_rst_out_val", 32'(io.out_val), 32'd0);

    // directed table, always-ready sink
    for (int v = 0; v < 8; v++) begin
      d = rand_line_data();
      log_q.delete();
      lines_q.push_back('{wben: vecs[v].wben, data: d});
      run(100, 0, 40);
      check("tbl_nbeats", 32'(log_q.size()), 32'(vecs[v].nbeats));
      for (int k = 0; k < log_q.size() && k < vecs[v].nbeats; k++) begin
        check("tbl_idx", 32'(log_q[k].idx), 32'(vecs[v].idxs[2*k +: 2]));
        check("tbl_bmask", 32'(log_q[k].bmask), 32'(vecs[v].bmasks[4*k +: 4]));
        check("tbl_data", log_q[k].data, d[32*vecs[v].idxs[2*k +: 2] +: 32]);
        check("tbl_last", 32'(log_q[k].last), 32'(k == vecs[v].nbeats - 1));
      end
    end

    // backpressure: first slot is the acceptance cycle, then 0,0,1,0,1,1,1
    log_q.delete();
    rdy_pat_q = '{1, 0, 0, 1, 0, 1, 1, 1};
    lines_q.push_back('{wben: 16'hFFFF, data: rand_line_data()});
    run(100, 0, 40);
    check("bp_nbeats", 32'(log_q.size()), 32'd4);
    for (int k = 0; k < log_q.size(); k++) check("bp_order", 32'(log_q[k].idx), 32'(k));

    // reset after beat idx1 fires
    d = rand_line_data();
    io.in_wben = 16'hFFFF;
    io.in_data = d;
    io.in_val  = 1'b1;
    io.out_rdy = 1'b1;
    #1;
    check("mr_accept", 32'(io.in_rdy), 32'd1);
    @(posedge clk); @(negedge clk);
    io.in_val = 1'b0;
    #1;
    check("mr_b0_val", 32'(io.out_val), 32'd1);
    check("mr_b0_idx", 32'(io.out_idx), 32'd0);
    @(posedge clk); @(negedge clk);
    #1;
    check("mr_b1_val", 32'(io.out_val), 32'd1);
    check("mr_b1_idx", 32'(io.out_idx), 32'd1);
    check("mr_b1_data", io.out_data, d[63:32]);
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    #1;
    check("mr_rst_val", 32'(io.out_val), 32'd0);
    check("mr_rst_in_rdy", 32'(io.in_rdy), 32'd0);
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("mr_after_val", 32'(io.out_val), 32'd0);
      check("mr_after_rdy", 32'(io.in_rdy), 32'd1);
      @(posedge clk); @(negedge clk);
    end
    log_q.delete();
    lines_q.push_back('{wben: 16'h000F, data: rand_line_data()});
    run(100, 0, 20);
    check("mr_new_nbeats", 32'(log_q.size()), 32'd1);
    if (log_q.size() != 0) check("mr_new_idx", 32'(log_q[0].idx), 32'd0);

    // back-to-back: second line held valid, accepted right after first's last fire
    log_q.delete();
    lines_q.push_back('{wben: 16'hFFFF, data: rand_line_data()});
    lines_q.push_back('{wben: 16'h0F0F, data: rand_line_data()});
    run(100, 0, 40);
    check("b2b_nbeats", 32'(log_q.size()), 32'd6);

    // random traffic
    io.domain = 1'b1;
    log_q.delete();
    for (int n = 0; n < 80; n++) begin
      l.data = rand_line_data();
      if ($urandom_range(7) == 0) l.wben = 16'h0000;
      else if ($urandom_range(5) == 0) l.wben = 16'hFFFF;
      else l.wben = 16'($urandom) & 16'($urandom);
      lines_q.push_back(l);
    end
    run(70, 30, 4000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
